// File: rtl/ps2_key_decoder.sv
// PS/2 scancode-set-2 decoder: turns raw received bytes into make/break key events
// with modifier tracking and ASCII translation, buffered in a first-word-fall-through FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter int EXT_EN     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  input  logic                          ev_ready,
  input  logic                          clr_overflow,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic [7:0]                    ev_ascii,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic [3:0]                    ev_mods,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_W-1:0]              press_cnt,
  output logic                          shift_flag,
  output logic                          ctrl_flag,
  output logic                          alt_flag,
  output logic                          caps_lock
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } entry_t;

  state_t state, state_nx;
  logic lshift, rshift, caps_held;
  logic lshift_nx, rshift_nx, caps_held_nx, ctrl_nx, alt_nx, caps_nx;
  logic fire, is_ext, is_brk;
  logic [7:0] ascii_nx;
  entry_t entry, head;
  entry_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop, drop;

  // Letter scancodes map to alphabet positions 1..26; 0 means not a letter
  function automatic logic [4:0] letter_idx(input logic [7:0] c);
    case (c)
      8'h1C: return 5'd1;   8'h32: return 5'd2;   8'h21: return 5'd3;
      8'h23: return 5'd4;   8'h24: return 5'd5;   8'h2B: return 5'd6;
      8'h34: return 5'd7;   8'h33: return 5'd8;   8'h43: return 5'd9;
      8'h3B: return 5'd10;  8'h42: return 5'd11;  8'h4B: return 5'd12;
      8'h3A: return 5'd13;  8'h31: return 5'd14;  8'h44: return 5'd15;
      8'h4D: return 5'd16;  8'h15: return 5'd17;  8'h2D: return 5'd18;
      8'h1B: return 5'd19;  8'h2C: return 5'd20;  8'h3C: return 5'd21;
      8'h2A: return 5'd22;  8'h1D: return 5'd23;  8'h22: return 5'd24;
      8'h35: return 5'd25;  8'h1A: return 5'd26;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic shift,
                                          input logic ctrl, input logic caps);
    logic [4:0] idx;
    idx = letter_idx(c);
    if (idx != 5'd0) begin
      if (ctrl)              return {3'b000, idx};
      else if (shift ^ caps) return 8'h40 + {3'b000, idx};
      else                   return 8'h60 + {3'b000, idx};
    end
    case (c)
      8'h16: return shift ? 8'h21 : 8'h31;
      8'h1E: return shift ? 8'h40 : 8'h32;
      8'h26: return shift ? 8'h23 : 8'h33;
      8'h25: return shift ? 8'h24 : 8'h34;
      8'h2E: return shift ? 8'h25 : 8'h35;
      8'h36: return shift ? 8'h5E : 8'h36;
      8'h3D: return shift ? 8'h26 : 8'h37;
      8'h3E: return shift ? 8'h2A : 8'h38;
      8'h46: return shift ? 8'h28 : 8'h39;
      8'h45: return shift ? 8'h29 : 8'h30;
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    is_ext   = 1'b0;
    is_brk   = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (in_data == 8'hE0) begin
            if (EXT_EN != 0) state_nx = EXT;
          end else if (in_data == 8'hF0) begin
            state_nx = BRK;
          end else if (!(in_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            fire = 1'b1;
          end
        end
        EXT: begin
          if (in_data == 8'hF0) state_nx = EXT_BRK;
          else if (in_data != 8'hE0) begin
            fire = 1'b1; is_ext = 1'b1; state_nx = IDLE;
          end
        end
        BRK: begin
          if (in_data != 8'hF0) begin
            fire = 1'b1; is_brk = 1'b1; state_nx = IDLE;
          end
        end
        default: begin
          if (in_data != 8'hF0) begin
            fire = 1'b1; is_ext = 1'b1; is_brk = 1'b1; state_nx = IDLE;
          end
        end
      endcase
    end
  end

  // Modifier state after the event is applied; it is both stored and tagged onto the event
  always_comb begin
    lshift_nx    = lshift;
    rshift_nx    = rshift;
    caps_held_nx = caps_held;
    ctrl_nx      = ctrl_flag;
    alt_nx       = alt_flag;
    caps_nx      = caps_lock;
    if (fire) begin
      if (!is_ext) begin
        case (in_data)
          8'h12: lshift_nx = !is_brk;
          8'h59: rshift_nx = !is_brk;
          8'h58: begin
            if (is_brk) caps_held_nx = 1'b0;
            else begin
              if (!caps_held) caps_nx = !caps_lock;
              caps_held_nx = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (in_data == 8'h14) ctrl_nx = !is_brk;
      if (in_data == 8'h11) alt_nx  = !is_brk;
    end
    ascii_nx = (is_ext || is_brk) ? 8'h00
             : to_ascii(in_data, lshift | rshift, ctrl_flag, caps_lock);
    entry = '{code: in_data, ascii: ascii_nx, ext: is_ext, brk: is_brk,
              mods: {caps_nx, alt_nx, ctrl_nx, lshift_nx | rshift_nx}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_held <= 1'b0;
      ctrl_flag <= 1'b0;
      alt_flag  <= 1'b0;
      caps_lock <= 1'b0;
      press_cnt <= '0;
    end else begin
      state     <= state_nx;
      lshift    <= lshift_nx;
      rshift    <= rshift_nx;
      caps_held <= caps_held_nx;
      ctrl_flag <= ctrl_nx;
      alt_flag  <= alt_nx;
      caps_lock <= caps_nx;
      if (fire && is_brk) press_cnt <= press_cnt + 1'b1;
    end
  end

  assign shift_flag = lshift | rshift;

  assign ev_valid = (count != '0);
  assign pop      = ev_valid & ev_ready;
  assign push     = fire & ((count != FULL) | pop);
  assign drop     = fire & (count == FULL) & !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // Storage is not reset; the head is masked while the FIFO is empty instead
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign head       = mem[rd_ptr];
  assign ev_code    = ev_valid ? head.code  : 8'h00;
  assign ev_ascii   = ev_valid ? head.ascii : 8'h00;
  assign ev_ext     = ev_valid & head.ext;
  assign ev_break   = ev_valid & head.brk;
  assign ev_mods    = ev_valid ? head.mods  : 4'h0;
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table of bytes with expected events fed
// through a scoreboard, plus hand-written overflow and mid-sequence reset scenarios.
module tb_ps2_key_decoder;

  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       ev;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, ev_ready, clr_overflow;
  logic       ev_valid, ev_ext, ev_break, overflow;
  logic [7:0] ev_code, ev_ascii;
  logic [3:0] ev_mods, fifo_count;
  logic [7:0] press_cnt;
  logic       shift_flag, ctrl_flag, alt_flag, caps_lock;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[$];

  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .EXT_EN(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .ev_ready(ev_ready), .clr_overflow(clr_overflow), .ev_valid(ev_valid),
    .ev_code(ev_code), .ev_ascii(ev_ascii), .ev_ext(ev_ext), .ev_break(ev_break),
    .ev_mods(ev_mods), .fifo_count(fifo_count), .overflow(overflow),
    .press_cnt(press_cnt), .shift_flag(shift_flag), .ctrl_flag(ctrl_flag),
    .alt_flag(alt_flag), .caps_lock(caps_lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] code, input logic [7:0] ascii,
                              input logic ext, input logic brk, input logic [3:0] mods);
    exp_t e;
    e.code = code; e.ascii = ascii; e.ext = ext; e.brk = brk; e.mods = mods;
    return e;
  endfunction

  task automatic ev(input logic [7:0] b, input logic [7:0] ascii, input logic ext,
                    input logic brk, input logic [3:0] mods);
    vec_t v;
    v.b = b; v.ev = 1'b1; v.e = mk(b, ascii, ext, brk, mods);
    tbl.push_back(v);
  endtask

  task automatic nv(input logic [7:0] b);
    vec_t v;
    v.b = b; v.ev = 1'b0; v.e = mk(8'h00, 8'h00, 1'b0, 1'b0, 4'h0);
    tbl.push_back(v);
  endtask

  // Drives one byte for a single cycle, optionally together with clr_overflow
  task automatic applyStimulus(input logic [7:0] b, input logic clr);
    @(posedge clk); #1;
    in_data = b; in_valid = 1'b1; clr_overflow = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || ev_valid) && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Scoreboard consumer: every event popped by the DUT is compared with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {24'h0, ev_code}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("ev_code",  ev_code,  e.code);
          check("ev_ascii", ev_ascii, e.ascii);
          check("ev_ext",   ev_ext,   e.ext);
          check("ev_break", ev_break, e.brk);
          check("ev_mods",  ev_mods,  e.mods);
        end
      end
    end
  end

  task automatic checkOutput(input string tag);
    check({tag, "_ev_valid"},   ev_valid,   0);
    check({tag, "_ev_code"},    ev_code,    0);
    check({tag, "_fifo_count"}, fifo_count, 0);
    check({tag, "_overflow"},   overflow,   0);
    check({tag, "_press_cnt"},  press_cnt,  0);
    check({tag, "_flags"}, {shift_flag, ctrl_flag, alt_flag, caps_lock}, 0);
  endtask

  initial begin
    int exp_cnt = 0;
    rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; ev_ready = 1'b1; clr_overflow = 1'b0;

    // ev(byte, ascii, ext, brk, mods{caps,alt,ctrl,shift}) / nv(byte) = no event expected
    ev(8'h1C, 8'h61, 0, 0, 4'h0); nv(8'hF0); ev(8'h1C, 8'h00, 0, 1, 4'h0);
    ev(8'h12, 8'h00, 0, 0, 4'h1); ev(8'h1C, 8'h41, 0, 0, 4'h1);
    nv(8'hF0); ev(8'h1C, 8'h00, 0, 1, 4'h1); nv(8'hF0); ev(8'h12, 8'h00, 0, 1, 4'h0);
    ev(8'h58, 8'h00, 0, 0, 4'h8); ev(8'h58, 8'h00, 0, 0, 4'h8);
    nv(8'hF0); ev(8'h58, 8'h00, 0, 1, 4'h8); ev(8'h1C, 8'h41, 0, 0, 4'h8);
    ev(8'h59, 8'h00, 0, 0, 4'h9); ev(8'h1C, 8'h61, 0, 0, 4'h9);
    nv(8'hF0); ev(8'h59, 8'h00, 0, 1, 4'h8);
    ev(8'h16, 8'h31, 0, 0, 4'h8); ev(8'h12, 8'h00, 0, 0, 4'h9);
    ev(8'h16, 8'h21, 0, 0, 4'h9); ev(8'h1E, 8'h40, 0, 0, 4'h9);
    nv(8'hF0); ev(8'h12, 8'h00, 0, 1, 4'h8);
    ev(8'h14, 8'h00, 0, 0, 4'hA); ev(8'h1C, 8'h01, 0, 0, 4'hA); ev(8'h1A, 8'h1A, 0, 0, 4'hA);
    nv(8'hF0); ev(8'h14, 8'h00, 0, 1, 4'h8);
    nv(8'hE0); ev(8'h75, 8'h00, 1, 0, 4'h8); nv(8'hE0); nv(8'hF0); ev(8'h75, 8'h00, 1, 1, 4'h8);
    nv(8'hE0); ev(8'h11, 8'h00, 1, 0, 4'hC); ev(8'h29, 8'h20, 0, 0, 4'hC);
    nv(8'hE0); nv(8'hF0); ev(8'h11, 8'h00, 1, 1, 4'h8);
    nv(8'hE0); nv(8'hE0); ev(8'h14, 8'h00, 1, 0, 4'hA); ev(8'h4D, 8'h10, 0, 0, 4'hA);
    nv(8'hE0); nv(8'hF0); nv(8'hF0); ev(8'h14, 8'h00, 1, 1, 4'h8);
    ev(8'h5A, 8'h0D, 0, 0, 4'h8); ev(8'h66, 8'h08, 0, 0, 4'h8);
    ev(8'h1A, 8'h5A, 0, 0, 4'h8); ev(8'h4D, 8'h50, 0, 0, 4'h8);
    nv(8'hFA); nv(8'hAA); nv(8'h00); nv(8'hFF);
    nv(8'hF0); nv(8'hF0); ev(8'h1C, 8'h00, 0, 1, 4'h8);
    ev(8'h58, 8'h00, 0, 0, 4'h0); nv(8'hF0); ev(8'h58, 8'h00, 0, 1, 4'h0);
    ev(8'h45, 8'h30, 0, 0, 4'h0); ev(8'h4D, 8'h70, 0, 0, 4'h0); ev(8'h0D, 8'h00, 0, 0, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ev) begin
        sb.push_back(tbl[i].e);
        if (tbl[i].e.brk) exp_cnt++;
      end
      applyStimulus(tbl[i].b, 1'b0);
    end
    wait_drain();
    check("press_cnt_table", press_cnt, exp_cnt);
    check("flags_table", {shift_flag, ctrl_flag, alt_flag, caps_lock}, 0);
    check("fifo_empty_after_drain", fifo_count, 0);

    // Fill past capacity with the consumer stalled; the head must survive the drop
    @(posedge clk); #1; ev_ready = 1'b0;
    applyStimulus(8'h1C, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(8'h16, 1'b0);
    check("full_count", fifo_count, 8);
    check("overflow_set", overflow, 1);
    check("head_code", ev_code, 8'h1C);
    check("head_ascii", ev_ascii, 8'h61);
    @(posedge clk); #1; clr_overflow = 1'b1;
    @(posedge clk); #1; clr_overflow = 1'b0;
    check("overflow_cleared", overflow, 0);
    applyStimulus(8'h16, 1'b1);
    check("drop_beats_clear", overflow, 1);
    check("full_count_kept", fifo_count, 8);
    @(posedge clk); #1; clr_overflow = 1'b1;
    @(posedge clk); #1; clr_overflow = 1'b0;
    check("overflow_cleared2", overflow, 0);
    sb.push_back(mk(8'h1C, 8'h61, 0, 0, 4'h0));
    for (int i = 0; i < 7; i++) sb.push_back(mk(8'h16, 8'h31, 0, 0, 4'h0));
    ev_ready = 1'b1;
    wait_drain();
    check("empty_after_overflow_drain", fifo_count, 0);

    // Reset in the middle of an E0 F0 sequence with shift held
    sb.push_back(mk(8'h12, 8'h00, 0, 0, 4'h1));
    applyStimulus(8'h12, 1'b0);
    wait_drain();
    check("shift_before_reset", shift_flag, 1);
    applyStimulus(8'hE0, 1'b0);
    applyStimulus(8'hF0, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    #1;
    checkOutput("midseq_reset");
    @(posedge clk); #1; rst = 1'b1;
    sb.push_back(mk(8'h16, 8'h31, 0, 0, 4'h0));
    applyStimulus(8'h16, 1'b0);
    wait_drain();
    check("press_cnt_after_reset", press_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
